// File: rtl/relu_conv_2d_pkg.sv
// Shared types and default widths for the relu_conv_2d accumulate/requant stage.
package relu_conv_2d_pkg;

   typedef enum logic {
      ACC = 1'b0,
      OUT = 1'b1
   } state_t;

   localparam int unsigned PROD_WIDTH_DEF = 21;
   localparam int unsigned ACC_WIDTH_DEF  = 32;
   localparam int unsigned OUT_WIDTH_DEF  = 8;
   localparam int unsigned KLEN_DEF       = 81;

endpackage

// File: rtl/relu_conv_2d_requant.sv
// Combinational requantiser: round-half-up arithmetic shift, ReLU, unsigned saturation.
module relu_conv_2d_requant
   import relu_conv_2d_pkg::*;
#(
   parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
   parameter int unsigned SHIFT     = 8,
   parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF
) (
   input  logic signed [ACC_WIDTH-1:0] t,
   output logic        [OUT_WIDTH-1:0] r,
   output logic                        clip
);

   localparam int unsigned EW = ACC_WIDTH + 1;
   localparam logic signed [EW-1:0] HALF = {{(EW-1){1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

   logic signed [EW-1:0] rounded;
   logic signed [EW-1:0] shifted;

   // One guard bit keeps the rounding add from wrapping at the top of the range.
   assign rounded = {t[ACC_WIDTH-1], t} + HALF;
   assign shifted = rounded >>> SHIFT;

   always_comb begin
      clip = 1'b0;
      r    = shifted[OUT_WIDTH-1:0];
      if (shifted[EW-1]) begin
         r    = '0;
         clip = 1'b1;
      end else if (shifted > MAXV) begin
         r    = '1;
         clip = 1'b1;
      end
   end

endmodule

// File: rtl/relu_conv_2d_acc_relu.sv
// Window accumulator with bias, requant and ReLU feeding a valid/ready output.
// Optional RELU_CONV_ACC_SAT_CNT_EN adds a saturating clip counter output sat_cnt.
module relu_conv_2d_acc_relu
   import relu_conv_2d_pkg::*;
#(
   parameter int unsigned PROD_WIDTH = PROD_WIDTH_DEF,
   parameter int unsigned BIAS_WIDTH = 16,
   parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
   parameter int unsigned KLEN       = KLEN_DEF,
   parameter int unsigned SHIFT      = 8,
   parameter int unsigned OUT_WIDTH  = OUT_WIDTH_DEF
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [PROD_WIDTH-1:0] s_prod,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [BIAS_WIDTH-1:0] bias,
   output logic [OUT_WIDTH-1:0]  m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  win_busy
`ifdef RELU_CONV_ACC_SAT_CNT_EN
   ,
   output logic [15:0]           sat_cnt
`endif
);

   localparam int unsigned CW   = (KLEN > 1) ? $clog2(KLEN) : 1;
   localparam int unsigned GROW = PROD_WIDTH + $clog2(KLEN);
   localparam int unsigned NEED = ((GROW > BIAS_WIDTH) ? GROW : BIAS_WIDTH) + 2;
   localparam logic [CW-1:0] LAST = CW'(KLEN - 1);

   if (KLEN < 1) begin : g_bad_klen
      $error("KLEN must be >= 1");
   end
   if (SHIFT < 1) begin : g_bad_shift
      $error("SHIFT must be >= 1");
   end
   if (ACC_WIDTH < NEED) begin : g_bad_acc
      $error("ACC_WIDTH too narrow for PROD_WIDTH, KLEN and BIAS_WIDTH");
   end

   state_t                 state, state_nxt;
   logic [CW-1:0]          cnt;
   logic signed [ACC_WIDTH-1:0] acc, base, sum;
   logic                   ready_en;
   logic                   beat, last;
   logic [OUT_WIDTH-1:0]   r;
   logic                   clip;

   assign last     = (cnt == LAST);
   assign beat     = s_valid && s_ready;
   assign win_busy = (cnt != '0);

   // Bias enters on the first beat so a KLEN==1 window still includes it.
   assign base = (cnt == '0) ? {{(ACC_WIDTH-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias} : acc;
   assign sum  = base + {{(ACC_WIDTH-PROD_WIDTH){1'b0}}, s_prod};

   relu_conv_2d_requant #(
      .ACC_WIDTH (ACC_WIDTH),
      .SHIFT     (SHIFT),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_requant (
      .t    (sum),
      .r    (r),
      .clip (clip)
   );

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) state <= ACC;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      m_valid   = 1'b0;
      case (state)
         ACC: begin
            s_ready = ready_en;
            if (s_valid && ready_en && last) state_nxt = OUT;
         end
         OUT: begin
            m_valid = 1'b1;
            if (m_ready) state_nxt = ACC;
         end
         default: state_nxt = ACC;
      endcase
   end

   // ready_en holds s_ready low until the first edge after reset release.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         ready_en <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
         m_data   <= '0;
      end else begin
         ready_en <= 1'b1;
         if (beat) begin
            if (last) begin
               cnt    <= '0;
               acc    <= '0;
               m_data <= r;
            end else begin
               cnt <= cnt + CW'(1);
               acc <= sum;
            end
         end
      end
   end

`ifdef RELU_CONV_ACC_SAT_CNT_EN
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) sat_cnt <= '0;
      else if (beat && last && clip && (sat_cnt != '1)) sat_cnt <= sat_cnt + 16'd1;
   end
`else
   logic unused_clip;
   assign unused_clip = clip;
`endif

endmodule

// File: tb/tb_relu_conv_2d_acc_relu.sv
// Directed bench for relu_conv_2d_acc_relu with KLEN=4, SHIFT=2 (sat_cnt checked under RELU_CONV_ACC_SAT_CNT_EN).
module tb_relu_conv_2d_acc_relu;

   logic        ap_clk;
   logic        ap_rst_n;
   logic [20:0] s_prod;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] bias;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        win_busy;
`ifdef RELU_CONV_ACC_SAT_CNT_EN
   logic [15:0] sat_cnt;
`endif

   int total = 0;
   int bad   = 0;

   relu_conv_2d_acc_relu #(
      .PROD_WIDTH (21),
      .BIAS_WIDTH (16),
      .ACC_WIDTH  (32),
      .KLEN       (4),
      .SHIFT      (2),
      .OUT_WIDTH  (8)
   ) dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .s_prod   (s_prod),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .bias     (bias),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .win_busy (win_busy)
`ifdef RELU_CONV_ACC_SAT_CNT_EN
      ,
      .sat_cnt  (sat_cnt)
`endif
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   // Four back-to-back beats; returns at the negedge after the last beat was taken.
   task automatic feed4(input logic [20:0] p0, input logic [20:0] p1,
                        input logic [20:0] p2, input logic [20:0] p3,
                        input logic [15:0] b, input string nm);
      logic [20:0] p [4];
      p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
      for (int i = 0; i < 4; i++) begin
         @(negedge ap_clk);
         if (i == 0) begin
            total++;
            if (s_ready !== 1'b1) begin
               bad++;
               $display("FAIL %s s_ready_start: got %0b expected 1", nm, s_ready);
            end
         end
         if (i == 2) begin
            total++;
            if (win_busy !== 1'b1) begin
               bad++;
               $display("FAIL %s win_busy_mid: got %0b expected 1", nm, win_busy);
            end
         end
         s_valid = 1'b1;
         s_prod  = p[i];
         bias    = b;
      end
      @(negedge ap_clk);
      s_valid = 1'b0;
   endtask

   task automatic run_window(input logic [20:0] p0, input logic [20:0] p1,
                             input logic [20:0] p2, input logic [20:0] p3,
                             input logic [15:0] b, input logic [7:0] exp, input string nm);
      m_ready = 1'b1;
      feed4(p0, p1, p2, p3, b, nm);
      total++;
      if (m_valid !== 1'b1 || m_data !== exp) begin
         bad++;
         $display("FAIL %s out: got valid=%0b data=%0d expected valid=1 data=%0d", nm, m_valid, m_data, exp);
      end
      total++;
      if (s_ready !== 1'b0 || win_busy !== 1'b0) begin
         bad++;
         $display("FAIL %s out_ready: got s_ready=%0b win_busy=%0b expected 0 0", nm, s_ready, win_busy);
      end
      @(negedge ap_clk);
      total++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s after: got valid=%0b s_ready=%0b expected 0 1", nm, m_valid, s_ready);
      end
   endtask

   task automatic check_sat(input logic [15:0] exp, input string nm);
`ifdef RELU_CONV_ACC_SAT_CNT_EN
      total++;
      if (sat_cnt !== exp) begin
         bad++;
         $display("FAIL %s sat_cnt: got %0d expected %0d", nm, sat_cnt, exp);
      end
`else
      if (exp == 16'hFFFF) $display("note %s", nm);
`endif
   endtask

   task automatic test_reset();
      ap_rst_n = 1'b0;
      s_valid  = 1'b0;
      s_prod   = '0;
      bias     = '0;
      m_ready  = 1'b1;
      #12;
      total++;
      if (m_valid !== 1'b0 || m_data !== 8'd0 || win_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: got valid=%0b data=%0d busy=%0b expected 0 0 0", m_valid, m_data, win_busy);
      end
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      total++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: got s_ready=%0b valid=%0b expected 1 0", s_ready, m_valid);
      end
      check_sat(16'd0, "reset");
   endtask

   task automatic test_basic();
      run_window(21'd10, 21'd20, 21'd30, 21'd40, 16'd0, 8'd25, "basic");
      check_sat(16'd0, "basic");
   endtask

   task automatic test_relu();
      // t = -100; (-100+2)>>>2 = -25 -> 0
      run_window(21'd10, 21'd20, 21'd30, 21'd40, -16'sd200, 8'd0, "relu");
      check_sat(16'd1, "relu");
   endtask

   task automatic test_saturate();
      run_window(21'd1000, 21'd1000, 21'd1000, 21'd1000, 16'd0, 8'd255, "sat");
      check_sat(16'd2, "sat");
   endtask

   task automatic test_rounding();
      run_window(21'd1, 21'd2, 21'd3, 21'd0, 16'd0, 8'd2, "round6");
      run_window(21'd1, 21'd1, 21'd1, 21'd2, 16'd0, 8'd1, "round5");
      // t = -2 rounds to exactly 0: not a clip
      run_window(21'd1, 21'd0, 21'd0, 21'd0, -16'sd3, 8'd0, "neg2");
      check_sat(16'd2, "neg2");
      // t = -3 rounds to -1: ReLU clip
      run_window(21'd1, 21'd0, 21'd0, 21'd0, -16'sd4, 8'd0, "neg3");
      check_sat(16'd3, "neg3");
      // 1021 -> 255 exactly, 1022 -> 256 clipped to 255
      run_window(21'd1000, 21'd21, 21'd0, 21'd0, 16'd0, 8'd255, "top_exact");
      check_sat(16'd3, "top_exact");
      run_window(21'd1000, 21'd22, 21'd0, 21'd0, 16'd0, 8'd255, "top_over");
      check_sat(16'd4, "top_over");
   endtask

   task automatic test_backpressure();
      m_ready = 1'b0;
      feed4(21'd10, 21'd20, 21'd30, 21'd40, 16'd0, "bp");
      s_valid = 1'b1;
      s_prod  = 21'd500;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (m_valid !== 1'b1 || m_data !== 8'd25 || s_ready !== 1'b0 || win_busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold%0d: got valid=%0b data=%0d s_ready=%0b busy=%0b expected 1 25 0 0",
                     i, m_valid, m_data, s_ready, win_busy);
         end
         if (i < 2) @(negedge ap_clk);
      end
      m_ready = 1'b1;
      s_valid = 1'b0;
      @(negedge ap_clk);
      total++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1 || win_busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_release: got valid=%0b s_ready=%0b busy=%0b expected 0 1 0", m_valid, s_ready, win_busy);
      end
      run_window(21'd1, 21'd2, 21'd3, 21'd0, 16'd0, 8'd2, "bp_fresh");
   endtask

   task automatic test_reset_mid();
      m_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge ap_clk);
         s_valid = 1'b1;
         s_prod  = 21'd300;
         bias    = 16'd0;
      end
      @(negedge ap_clk);
      s_valid = 1'b0;
      total++;
      if (win_busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_busy: got %0b expected 1", win_busy);
      end
      ap_rst_n = 1'b0;
      #1;
      total++;
      if (m_valid !== 1'b0 || win_busy !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset: got valid=%0b busy=%0b expected 0 0", m_valid, win_busy);
      end
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      run_window(21'd10, 21'd20, 21'd30, 21'd40, 16'd0, 8'd25, "after_reset");
      check_sat(16'd0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_relu();
      test_saturate();
      test_rounding();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
